mem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - the pipeline MEM stage (CPU);
  - an image DMA engine that streams pixel bytes in and out of data memory.
- Grants exactly one requester per cycle and supports DMA bursts.
- Guarantees DMA forward progress with a starvation counter.
- Generates a stall to freeze the CPU pipeline while the port is lost.
- Sits between the EXE/MEM pipeline register and the data memory inside the MEM stage.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the MEM-stage data-memory port between the CPU pipeline
//            and an image DMA engine. DMA gets bounded bursts, a starvation
//            counter forces DMA in after MAX_WAIT lost cycles, and the CPU is
//            stalled whenever it requests but does not own the port.
// Options  : ARB_STATS_EN - when defined, enables the saturating 16-bit
//            stall / DMA-beat statistics counters (tied to zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 8,
  parameter int RW        = 32,
  parameter int BURST_MAX = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_cpu,
  input  logic          we_cpu,
  input  logic [AW-1:0] addr_cpu,
  input  logic [DW-1:0] wdata_cpu,
  input  logic          req_dma,
  input  logic          we_dma,
  input  logic [AW-1:0] addr_dma,
  input  logic [DW-1:0] wdata_dma,
  input  logic [RW-1:0] mem_rdata,
  output logic          gnt_cpu,
  output logic          gnt_dma,
  output logic          stall_cpu,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [RW-1:0] rdata,
  output logic          rvalid_cpu,
  output logic          rvalid_dma,
  output logic [15:0]   stat_stall,
  output logic [15:0]   stat_dma
);

  localparam int c_BW = $clog2(BURST_MAX + 1);
  localparam int c_WW = $clog2(MAX_WAIT + 1);
  localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(BURST_MAX);
  localparam logic [c_WW-1:0] c_MAX_WAIT  = c_WW'(MAX_WAIT);

  // State records which requester owned the port in the current cycle.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CPU       = 2'd1,
    S_DMA_BURST = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_BW-1:0] r_beat_cnt;
  logic [c_BW-1:0] w_beat_nxt;
  logic [c_WW-1:0] r_wait_cnt;
  logic [c_WW-1:0] w_wait_nxt;
  logic            w_gnt_cpu;
  logic            w_gnt_dma;
  logic            w_burst_start;
  logic [AW-1:0]   r_last_addr;
  logic [DW-1:0]   r_last_wdata;
  logic [RW-1:0]   r_rdata;
  logic            r_rvalid_cpu;
  logic            r_rvalid_dma;

  // Registered owner state and burst / starvation counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Priority grant: burst continuation, forced preemption, CPU, then new DMA burst.
  always_comb begin
    w_gnt_cpu     = 1'b0;
    w_gnt_dma     = 1'b0;
    w_burst_start = 1'b0;
    w_state_nxt   = S_IDLE;
    w_beat_nxt    = '0;
    w_wait_nxt    = r_wait_cnt;

    if (r_state == S_DMA_BURST && req_dma && r_beat_cnt < c_BURST_MAX) begin
      w_gnt_dma = 1'b1;
    end else if (req_dma && r_wait_cnt == c_MAX_WAIT) begin
      w_gnt_dma     = 1'b1;
      w_burst_start = 1'b1;
    end else if (req_cpu) begin
      w_gnt_cpu = 1'b1;
    end else if (req_dma) begin
      w_gnt_dma     = 1'b1;
      w_burst_start = 1'b1;
    end

    if (w_gnt_dma) begin
      w_state_nxt = S_DMA_BURST;
      w_beat_nxt  = w_burst_start ? c_BW'(1) : r_beat_cnt + c_BW'(1);
      w_wait_nxt  = '0;
    end else begin
      if (w_gnt_cpu) begin
        w_state_nxt = S_CPU;
      end
      if (req_dma && r_wait_cnt != c_MAX_WAIT) begin
        w_wait_nxt = r_wait_cnt + c_WW'(1);
      end
    end
  end

  // Memory port mux; address and write byte park on their last driven value.
  always_comb begin
    mem_addr  = r_last_addr;
    mem_wdata = r_last_wdata;
    mem_we    = 1'b0;
    if (w_gnt_cpu) begin
      mem_addr  = addr_cpu;
      mem_wdata = wdata_cpu;
      mem_we    = we_cpu;
    end else if (w_gnt_dma) begin
      mem_addr  = addr_dma;
      mem_wdata = wdata_dma;
      mem_we    = we_dma;
    end
  end

  // Remember the last driven address / write byte for idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_last_addr  <= mem_addr;
      r_last_wdata <= mem_wdata;
    end
  end

  // Read return: one-cycle registered data with per-requester valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata      <= '0;
      r_rvalid_cpu <= 1'b0;
      r_rvalid_dma <= 1'b0;
    end else begin
      r_rdata      <= mem_rdata;
      r_rvalid_cpu <= w_gnt_cpu & ~we_cpu;
      r_rvalid_dma <= w_gnt_dma & ~we_dma;
    end
  end

  assign gnt_cpu    = w_gnt_cpu;
  assign gnt_dma    = w_gnt_dma;
  assign stall_cpu  = req_cpu & ~w_gnt_cpu;
  assign rdata      = r_rdata;
  assign rvalid_cpu = r_rvalid_cpu;
  assign rvalid_dma = r_rvalid_dma;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_dma;

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_stall <= 16'h0000;
      r_stat_dma   <= 16'h0000;
    end else begin
      if (stall_cpu && r_stat_stall != 16'hFFFF) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (w_gnt_dma && r_stat_dma != 16'hFFFF) begin
        r_stat_dma <= r_stat_dma + 16'd1;
      end
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_dma   = r_stat_dma;
`else
  assign stat_stall = 16'h0000;
  assign stat_dma   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed vector table,
//            starvation and mid-burst reset sequences, then random traffic,
//            all checked against a behavioural ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 8;
  localparam int RW        = 32;
  localparam int BURST_MAX = 4;
  localparam int MAX_WAIT  = 8;

  logic          clk;
  logic          rst_n;
  logic          req_cpu, we_cpu, req_dma, we_dma;
  logic [AW-1:0] addr_cpu, addr_dma;
  logic [DW-1:0] wdata_cpu, wdata_dma;
  logic [RW-1:0] mem_rdata;
  logic          gnt_cpu, gnt_dma, stall_cpu, mem_we, rvalid_cpu, rvalid_dma;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] rdata;
  logic [15:0]   stat_stall, stat_dma;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .RW(RW), .BURST_MAX(BURST_MAX), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cpu(req_cpu), .we_cpu(we_cpu), .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu),
    .req_dma(req_dma), .we_dma(we_dma), .addr_dma(addr_dma), .wdata_dma(wdata_dma),
    .mem_rdata(mem_rdata),
    .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma), .stall_cpu(stall_cpu),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .rdata(rdata), .rvalid_cpu(rvalid_cpu), .rvalid_dma(rvalid_dma),
    .stat_stall(stat_stall), .stat_dma(stat_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Behavioural model: who owns the port, how long the burst has run,
  // how long DMA has been waiting, plus the registered read-return state.
  bit            m_dma_owner;
  int            m_beats;
  int            m_wait;
  bit            m_rvc, m_rvd;
  logic [RW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_ss, m_sd;

  // Mid-cycle DUT samples for the vector table.
  logic s_gc, s_gd, s_st, s_we;

  typedef struct {
    logic          rc, wc;
    logic [AW-1:0] ac;
    logic [DW-1:0] dc;
    logic          rd, wd;
    logic [AW-1:0] ad;
    logic [DW-1:0] dd;
    logic          egc, egd, est, ewe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rc, input logic wc, input logic [AW-1:0] ac,
                              input logic [DW-1:0] dc, input logic rd, input logic wd,
                              input logic [AW-1:0] ad, input logic [DW-1:0] dd,
                              input logic egc, input logic egd, input logic est,
                              input logic ewe);
    vec_t v;
    v.rc = rc; v.wc = wc; v.ac = ac; v.dc = dc;
    v.rd = rd; v.wd = wd; v.ad = ad; v.dd = dd;
    v.egc = egc; v.egd = egd; v.est = est; v.ewe = ewe;
    return v;
  endfunction

  task automatic model_reset();
    m_dma_owner = 0; m_beats = 0; m_wait = 0;
    m_rvc = 0; m_rvd = 0; m_rdata = '0;
    m_addr = '0; m_wdata = '0; m_ss = 0; m_sd = 0;
  endtask

  task automatic chk_stats();
`ifdef ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'(m_ss));
    chk("stat_dma", 64'(stat_dma), 64'(m_sd));
`else
    chk("stat_stall", 64'(stat_stall), 64'd0);
    chk("stat_dma", 64'(stat_dma), 64'd0);
`endif
  endtask

  // One clock cycle: entered 1 ns after a rising edge, leaves the same way.
  task automatic step(input logic rc, input logic wc, input logic [AW-1:0] ac,
                      input logic [DW-1:0] dc, input logic rd, input logic wd,
                      input logic [AW-1:0] ad, input logic [DW-1:0] dd);
    bit            eg_c, eg_d, start, e_we, e_st;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    req_cpu = rc; we_cpu = wc; addr_cpu = ac; wdata_cpu = dc;
    req_dma = rd; we_dma = wd; addr_dma = ad; wdata_dma = dd;
    mem_rdata = $urandom;
    #4;
    eg_c = 0; eg_d = 0; start = 0;
    if (m_dma_owner && rd && m_beats < BURST_MAX) begin
      eg_d = 1;
    end else if (rd && m_wait >= MAX_WAIT) begin
      eg_d = 1; start = 1;
    end else if (rc) begin
      eg_c = 1;
    end else if (rd) begin
      eg_d = 1; start = 1;
    end
    e_addr  = eg_c ? ac : (eg_d ? ad : m_addr);
    e_wdata = eg_c ? dc : (eg_d ? dd : m_wdata);
    e_we    = eg_c ? wc : (eg_d ? wd : 1'b0);
    e_st    = rc && !eg_c;
    s_gc = gnt_cpu; s_gd = gnt_dma; s_st = stall_cpu; s_we = mem_we;
    chk("gnt_cpu", 64'(gnt_cpu), 64'(eg_c));
    chk("gnt_dma", 64'(gnt_dma), 64'(eg_d));
    chk("stall_cpu", 64'(stall_cpu), 64'(e_st));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("rvalid_cpu", 64'(rvalid_cpu), 64'(m_rvc));
    chk("rvalid_dma", 64'(rvalid_dma), 64'(m_rvd));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk_stats();
    @(posedge clk);
    m_rvc   = eg_c && !wc;
    m_rvd   = eg_d && !wd;
    m_rdata = mem_rdata;
    m_addr  = e_addr;
    m_wdata = e_wdata;
    if (eg_d) begin
      m_beats = start ? 1 : m_beats + 1;
      m_wait  = 0;
    end else begin
      m_beats = 0;
      if (rd && m_wait < MAX_WAIT) m_wait++;
    end
    m_dma_owner = eg_d;
    if (e_st && m_ss < 16'hFFFF) m_ss++;
    if (eg_d && m_sd < 16'hFFFF) m_sd++;
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    req_cpu = 0; we_cpu = 0; addr_cpu = '0; wdata_cpu = '0;
    req_dma = 0; we_dma = 0; addr_dma = '0; wdata_dma = '0;
    mem_rdata = '0;
    model_reset();

    // Reset state.
    #3;
    chk("rst_gnt_cpu", 64'(gnt_cpu), 64'd0);
    chk("rst_gnt_dma", 64'(gnt_dma), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rvalid_cpu", 64'(rvalid_cpu), 64'd0);
    chk("rst_rvalid_dma", 64'(rvalid_dma), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk_stats();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector table (expected grants hand-derived from the rules).
    for (int i = 0; i < 3; i++)     // CPU-only reads at 0x10
      tbl.push_back(mk(1, 0, 32'h10, 8'h00, 0, 0, 32'h0, 8'h00, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)     // DMA alone: burst of 4 then a new burst
      tbl.push_back(mk(0, 0, 32'h0, 8'h00, 1, 0, 32'h100 + 32'(i), 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 1, 0, 32'h300, 8'h00, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)     // CPU arrives at beat 2: stalled to beat 4
      tbl.push_back(mk(1, 0, 32'h20, 8'h00, 1, 0, 32'h301 + 32'(i), 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h20, 8'h00, 1, 0, 32'h304, 8'h00, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h44, 8'h3C, 0, 0, 32'h0, 8'h00, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 1, 1, 32'h200, 8'hA5, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 8'h00, 0, 0, 32'h0, 8'h00, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      step(tbl[i].rc, tbl[i].wc, tbl[i].ac, tbl[i].dc,
           tbl[i].rd, tbl[i].wd, tbl[i].ad, tbl[i].dd);
      chk("tbl_gnt_cpu", 64'(s_gc), 64'(tbl[i].egc));
      chk("tbl_gnt_dma", 64'(s_gd), 64'(tbl[i].egd));
      chk("tbl_stall", 64'(s_st), 64'(tbl[i].est));
      chk("tbl_mem_we", 64'(s_we), 64'(tbl[i].ewe));
    end

    // Starvation: 8 CPU cycles, forced DMA on the 9th, 4-beat burst, CPU again.
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 32'h40, 8'h00, 1, 0, 32'h400 + 32'(i), 8'h00);
      chk("starve_gnt_cpu", 64'(s_gc), (i < 8 || i == 12) ? 64'd1 : 64'd0);
      chk("starve_gnt_dma", 64'(s_gd), (i >= 8 && i < 12) ? 64'd1 : 64'd0);
      chk("starve_stall", 64'(s_st), (i >= 8 && i < 12) ? 64'd1 : 64'd0);
    end
    idle();

    // Reset in the middle of a DMA read burst.
    step(0, 0, '0, '0, 1, 0, 32'h500, 8'h00);
    step(0, 0, '0, '0, 1, 0, 32'h501, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid_cpu", 64'(rvalid_cpu), 64'd0);
    chk("midrst_rvalid_dma", 64'(rvalid_dma), 64'd0);
    chk("midrst_rdata", 64'(rdata), 64'd0);
    model_reset();
    chk_stats();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 1, 0, 32'h600 + 32'(i), 8'h00);
      chk("postrst_gnt_dma", 64'(s_gd), 64'd1);
    end
    step(1, 0, 32'h80, 8'h00, 1, 0, 32'h604, 8'h00);
    chk("postrst_burst_end", 64'(s_gc), 64'd1);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom, 8'($urandom),
           $urandom_range(0, 2) != 0, 1'($urandom), $urandom, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire
